// File: rtl/dffre_pkg.sv
// -----------------------------------------------------------------------------
// dffre_pkg
// Shared constants and types for the dffre register family.
//   DFFRE_DEFAULT_WIDTH       : default data width of dffre_inst
//   DFFRE_MAX_WIDTH           : widest supported data word
//   DFFRE_DEFAULT_RESET_VALUE : default reset / power-up value, sliced to
//                               WIDTH bits by the user of the package
//   dffre_word_t              : data word at the default width
// -----------------------------------------------------------------------------
package dffre_pkg;

  localparam int DFFRE_DEFAULT_WIDTH = 1;
  localparam int DFFRE_MAX_WIDTH     = 64;

  localparam logic [DFFRE_MAX_WIDTH-1:0] DFFRE_DEFAULT_RESET_VALUE = 64'h0;

  typedef logic [DFFRE_DEFAULT_WIDTH-1:0] dffre_word_t;

endpackage : dffre_pkg

// File: rtl/dffre_cell.sv
// -----------------------------------------------------------------------------
// dffre_cell
// One-bit D flip-flop with synchronous active-high reset and clock enable.
// Written so it maps onto a single FPGA flop primitive using its sync-reset
// and clock-enable pins, with nothing else in the data path.
//   clk      : rising-edge clock
//   i_Reset  : synchronous reset, loads RESET_VALUE, wins over i_Enable
//   i_Enable : load enable
//   i_D      : data input
//   o_Q      : registered data output
// Parameter RESET_VALUE is also the power-up value of the flop.
// -----------------------------------------------------------------------------
module dffre_cell #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic i_Reset,
  input  logic i_Enable,
  input  logic i_D,
  output logic o_Q
);

  // Declaration initialiser becomes the flop INIT value, so the output is
  // defined from time 0 without needing a reset pulse.
  logic q_r = RESET_VALUE;

  // Storage bit: reset first, then enabled load, otherwise hold.
  always_ff @(posedge clk) begin
    if (i_Reset) begin
      q_r <= RESET_VALUE;
    end else if (i_Enable) begin
      q_r <= i_D;
    end else begin
      q_r <= q_r;
    end
  end

  assign o_Q = q_r;

endmodule : dffre_cell

// File: rtl/dffre_inst_sva.sv
// -----------------------------------------------------------------------------
// dffre_inst_sva
// Concurrent-assertion checker bound into dffre_inst when DFFRE_INST_SVA_EN is
// defined. Without the macro this file compiles to nothing.
//   clk, i_Reset, i_Enable, i_D, o_Q : observed copies of the dffre_inst ports
// Checks each cycle: reset loads RESET_VALUE (also when enabled), enabled
// load captures the previous-edge data, idle cycles hold, and the control
// inputs are never X/Z at an edge.
// -----------------------------------------------------------------------------
`ifdef DFFRE_INST_SVA_EN
module dffre_inst_sva #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input logic             clk,
  input logic             i_Reset,
  input logic             i_Enable,
  input logic [WIDTH-1:0] i_D,
  input logic [WIDTH-1:0] o_Q
);

  a_reset: assert property (@(posedge clk) i_Reset |=> (o_Q == RESET_VALUE))
    else $error("dffre_inst: reset did not load RESET_VALUE");

  a_priority: assert property (@(posedge clk) (i_Reset && i_Enable) |=> (o_Q == RESET_VALUE))
    else $error("dffre_inst: enable overrode reset");

  a_load: assert property (@(posedge clk) (!i_Reset && i_Enable) |=> (o_Q == $past(i_D)))
    else $error("dffre_inst: enabled load did not capture i_D");

  a_hold: assert property (@(posedge clk) (!i_Reset && !i_Enable) |=> (o_Q == $past(o_Q)))
    else $error("dffre_inst: output changed while idle");

  a_ctrl_known: assert property (@(posedge clk) !$isunknown({i_Reset, i_Enable}))
    else $error("dffre_inst: X/Z on i_Reset or i_Enable");

endmodule : dffre_inst_sva
`endif

// File: rtl/dffre_inst.sv
// -----------------------------------------------------------------------------
// dffre_inst
// WIDTH-bit register with synchronous active-high reset and load enable,
// built from one dffre_cell per bit so every bit is an independent flop that
// shares reset and enable.
//   clk      : rising-edge clock
//   i_Reset  : synchronous reset to RESET_VALUE, priority over i_Enable
//   i_Enable : load enable
//   i_D      : WIDTH-bit data input
//   o_Q      : WIDTH-bit registered output, RESET_VALUE at power-up
// Parameters: WIDTH (1..64), RESET_VALUE (WIDTH bits).
// Optional macro DFFRE_INST_SVA_EN adds the dffre_inst_sva assertion checker;
// it only observes ports, so the synthesized logic is the same either way.
// -----------------------------------------------------------------------------
module dffre_inst
  import dffre_pkg::*;
#(
  parameter int               WIDTH       = DFFRE_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = DFFRE_DEFAULT_RESET_VALUE[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             i_Reset,
  input  logic             i_Enable,
  input  logic [WIDTH-1:0] i_D,
  output logic [WIDTH-1:0] o_Q
);

  logic [WIDTH-1:0] q_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dffre_cell #(
      .RESET_VALUE (RESET_VALUE[i])
    ) u_cell (
      .clk      (clk),
      .i_Reset  (i_Reset),
      .i_Enable (i_Enable),
      .i_D      (i_D[i]),
      .o_Q      (q_s[i])
    );
  end

  assign o_Q = q_s;

`ifdef DFFRE_INST_SVA_EN
  dffre_inst_sva #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_sva (
    .clk      (clk),
    .i_Reset  (i_Reset),
    .i_Enable (i_Enable),
    .i_D      (i_D),
    .o_Q      (o_Q)
  );
`endif

endmodule : dffre_inst

// File: tb/tb_dffre_inst.sv
// -----------------------------------------------------------------------------
// tb_dffre_inst
// Self-checking bench for dffre_inst. Two instances share clock, reset and
// enable: a default 1-bit register and an 8-bit register with a non-zero
// reset value. The expected outputs come from a behavioural model that just
// applies the reset / load / hold rule at each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dffre_inst;

  localparam logic [7:0] RV8 = 8'h5A;

  logic       clk = 1'b0;
  logic       rst_s = 1'b0;
  logic       en_s  = 1'b0;
  logic       d1_s  = 1'b1;
  logic [7:0] d8_s  = 8'hFF;
  logic       q1_s;
  logic [7:0] q8_s;

  // Behavioural model state
  logic       m_q1 = 1'b0;
  logic [7:0] m_q8 = RV8;

  int n_checks = 0;
  int n_errors = 0;

  dffre_inst u_dut1 (
    .clk      (clk),
    .i_Reset  (rst_s),
    .i_Enable (en_s),
    .i_D      (d1_s),
    .o_Q      (q1_s)
  );

  dffre_inst #(
    .WIDTH       (8),
    .RESET_VALUE (RV8)
  ) u_dut8 (
    .clk      (clk),
    .i_Reset  (rst_s),
    .i_Enable (en_s),
    .i_D      (d8_s),
    .o_Q      (q8_s)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "_w1"}, {63'd0, q1_s}, {63'd0, m_q1});
    check({tag, "_w8"}, {56'd0, q8_s}, {56'd0, m_q8});
  endtask

  // Apply inputs away from the edge, let one rising edge happen, advance the
  // model by the register rule, then compare shortly after the edge.
  task automatic step(input logic r, input logic e, input logic d1,
                      input logic [7:0] d8, input string tag);
    @(negedge clk);
    rst_s = r;
    en_s  = e;
    d1_s  = d1;
    d8_s  = d8;
    @(posedge clk);
    if (r) begin
      m_q1 = 1'b0;
      m_q8 = RV8;
    end else if (e) begin
      m_q1 = d1;
      m_q8 = d8;
    end
    #2;
    check_both(tag);
  endtask

  initial begin
    logic       r_v;
    logic       e_v;
    logic       d1_v;
    logic [7:0] d8_v;

    // Power-up value, before any edge
    #1;
    check_both("powerup");

    // Idle edges with data high: power-up value is held
    step(1'b0, 1'b0, 1'b1, 8'hFF, "powerup_hold");
    step(1'b0, 1'b0, 1'b1, 8'h00, "powerup_hold2");

    // Reset with enable and data high for two edges
    step(1'b1, 1'b1, 1'b1, 8'hFF, "rst_en_a");
    step(1'b1, 1'b1, 1'b1, 8'hC3, "rst_en_b");

    // Reset held while enable and data toggle
    step(1'b1, 1'b0, 1'b0, 8'h00, "rst_hold_0");
    step(1'b1, 1'b1, 1'b0, 8'h0F, "rst_hold_1");
    step(1'b1, 1'b0, 1'b1, 8'hF0, "rst_hold_2");
    step(1'b1, 1'b1, 1'b1, 8'hFF, "rst_hold_3");

    // First edge after reset release loads immediately, then follows data
    step(1'b0, 1'b1, 1'b1, 8'hA5, "load_1");
    step(1'b0, 1'b1, 1'b0, 8'h3C, "load_0");

    // Load a one, then hold while data toggles
    step(1'b0, 1'b1, 1'b1, 8'h96, "load_hold_pre");
    step(1'b0, 1'b0, 1'b0, 8'h00, "hold_0");
    step(1'b0, 1'b0, 1'b1, 8'hFF, "hold_1");
    step(1'b0, 1'b0, 1'b0, 8'h11, "hold_2");

    // Reset and enable pulsed strictly between edges must not disturb the output
    @(negedge clk);
    rst_s = 1'b0;
    en_s  = 1'b0;
    #1;
    rst_s = 1'b1;
    en_s  = 1'b1;
    d1_s  = 1'b0;
    d8_s  = 8'h00;
    #1;
    check_both("mid_pulse");
    rst_s = 1'b0;
    en_s  = 1'b0;
    @(posedge clk);
    #2;
    check_both("after_mid_pulse");
    rst_s = 1'b1;
    #1;
    check_both("reset_between_edges");

    // Streaming load: output is always the previous-edge data
    for (int i = 0; i < 1000; i++) begin
      d1_v = 1'($urandom);
      d8_v = 8'($urandom);
      step(1'b0, 1'b1, d1_v, d8_v, "stream");
    end

    // Fully random control mix, reset kept infrequent
    for (int i = 0; i < 300; i++) begin
      r_v  = ($urandom_range(7, 0) == 0) ? 1'b1 : 1'b0;
      e_v  = 1'($urandom);
      d1_v = 1'($urandom);
      d8_v = 8'($urandom);
      step(r_v, e_v, d1_v, d8_v, "random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_dffre_inst

// File: doc/dffre_inst.md
DFFRE_INST -- requirements
Module: dffre_inst

Interface
REQ-001 Parameter WIDTH, default 1, data width of i_D/o_Q in bits (legal range 1..64).
REQ-002 Parameter RESET_VALUE, default '0 (all zeros), WIDTH-bit value loaded by reset and used as power-up value.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port i_Reset  input  1  synchronous, active-high reset.
REQ-005 Port i_Enable  input  1  active-high load enable.
REQ-006 Port i_D  input  WIDTH  data input.
REQ-007 Port o_Q  output  WIDTH  registered data output.
REQ-008 Port order SHALL be clk, i_Reset, i_Enable, i_D, o_Q, so positional instantiation is legal.
REQ-009 dffre_inst_post_route (post-route netlist) SHALL expose the identical port list and behaviour.

Function
REQ-010 On each rising clk edge, o_Q SHALL become RESET_VALUE if i_Reset=1.
REQ-011 Otherwise, o_Q SHALL become i_D if i_Enable=1.
REQ-012 Otherwise (i_Reset=0, i_Enable=0), o_Q SHALL hold its previous value.
REQ-013 Reset SHALL take priority over enable; i_Reset=1 with i_Enable=1 yields RESET_VALUE.
REQ-014 Latency i_D -> o_Q SHALL be exactly one clk edge; no combinational path from any input to o_Q.
REQ-015 Input changes between edges SHALL NOT affect o_Q.
REQ-016 Each bit of o_Q SHALL follow REQ-010..012 independently, with shared i_Reset/i_Enable.
REQ-017 o_Q SHALL be X-free from time 0: power-up value RESET_VALUE.

Reset
REQ-018 Reset SHALL be synchronous and active-high; assertion or deassertion between edges SHALL NOT change o_Q.
REQ-019 While i_Reset stays high, o_Q SHALL remain RESET_VALUE regardless of i_Enable and i_D.
REQ-020 On the first edge after i_Reset falls, normal enable/data behaviour SHALL resume immediately.

Configuration
REQ-021 Macro DFFRE_INST_SVA_EN: when defined, the module SHALL compile in concurrent assertions checking REQ-010..013 each cycle, plus an X/Z check on i_Reset and i_Enable; a failure SHALL report via $error.
REQ-022 Without DFFRE_INST_SVA_EN, no assertion code SHALL be compiled; the synthesized logic SHALL be identical in both cases.

Structure
REQ-023 Package dffre_pkg SHALL hold the default WIDTH and RESET_VALUE constants and a typedef for the WIDTH-bit data word.
REQ-024 Sub-module dffre_cell (1-bit flop with sync reset and enable, reset-value parameter) SHALL be instantiated WIDTH times via generate.
REQ-025 Mapping SHALL target a single FPGA DFF primitive with sync-reset and clock-enable pins per bit; no extra LUT logic in the data path.

Verification
REQ-026 Bench SHALL compare dffre_inst against dffre_inst_post_route with 4-state (!==) comparison, sampling on the falling edge, and count mismatches.
REQ-027 Power-up, i_Reset=0, i_Enable=0, i_D=1 -> o_Q=0 (power-up value held).
REQ-028 i_Reset=1, i_Enable=1, i_D=1 for 2 edges -> o_Q=0.
REQ-029 i_Reset=1, toggle i_Enable 0->1 and i_D 0->1 over 4 edges -> o_Q=0 throughout.
REQ-030 i_Reset=0, i_Enable=1, i_D=1 -> o_Q=1 after one edge; then i_D=0 -> o_Q=0 after next edge.
REQ-031 i_Reset=0, i_Enable=0, o_Q=1, i_D toggled 0/1 for 3 edges -> o_Q stays 1.
REQ-032 1000 random i_D values, i_Enable=1, i_Reset=0 -> o_Q equals previous-edge i_D every cycle; mismatch count 0 required for pass.
